// File: rtl/rba_mp_ckpt.sv
// Ready-bit array for the PRF with CDB forwarding and branch checkpoints.
// Mispredict recovery restores live bits from a slot, merged with same-cycle CDB sets.
module rba_mp_ckpt #(
  parameter int DEPTH    = 48,
  parameter int ADDR_W   = 6,
  parameter int NUM_RD   = 4,
  parameter int NUM_CDB  = 2,
  parameter int NUM_CKPT = 4,
  parameter int CK_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]         rd_dout,
  input  logic                      du_clr_en,
  input  logic [ADDR_W-1:0]         du_clr_addr,
  input  logic [NUM_CDB-1:0]        cdb_set_en,
  input  logic [NUM_CDB*ADDR_W-1:0] cdb_set_addr,
  input  logic                      ckpt_save_en,
  input  logic [CK_W-1:0]           ckpt_save_id,
  input  logic                      ckpt_free_en,
  input  logic [CK_W-1:0]           ckpt_free_id,
  input  logic                      ckpt_restore_en,
  input  logic [CK_W-1:0]           ckpt_restore_id,
  output logic [NUM_CKPT-1:0]       ckpt_valid,
  output logic                      ckpt_err
);

  logic [DEPTH-1:0]    live;
  logic [DEPTH-1:0]    live_nxt;
  logic [DEPTH-1:0]    set_mask;
  logic [DEPTH-1:0]    clr_mask;
  logic [DEPTH-1:0]    fwd;
  logic [DEPTH-1:0]    ckpt_sel;
  logic [DEPTH-1:0]    ckpt [NUM_CKPT];
  logic [NUM_CKPT-1:0] valid_nxt;
  logic                rvalid;
  logic                save_ok;
  logic                free_bad;
  logic                rest_bad;
  logic                err_nxt;

  // Address decode; out-of-range addresses never match a bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int b = 0; b < DEPTH; b++) begin
      for (int j = 0; j < NUM_CDB; j++) begin
        if (cdb_set_en[j] &&
            cdb_set_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(b))
          set_mask[b] = 1'b1;
      end
      if (du_clr_en && du_clr_addr == ADDR_W'(b))
        clr_mask[b] = 1'b1;
    end
  end

  assign fwd = live | set_mask;

  always_comb begin
    rd_dout = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int b = 0; b < DEPTH; b++) begin
        if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(b))
          rd_dout[i] = fwd[b];
      end
    end
  end

  always_comb begin
    ckpt_sel = '0;
    rvalid   = 1'b0;
    free_bad = ckpt_free_en;
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (ckpt_restore_id == CK_W'(k)) begin
        ckpt_sel = ckpt[k];
        rvalid   = ckpt_restore_en && ckpt_valid[k];
      end
      if (ckpt_free_id == CK_W'(k) && ckpt_valid[k])
        free_bad = 1'b0;
    end
    rest_bad = ckpt_restore_en && !rvalid;
    save_ok  = ckpt_save_en && !ckpt_restore_en;
    err_nxt  = free_bad || rest_bad;
    live_nxt = rvalid ? (ckpt_sel | set_mask)
                      : ((live & ~clr_mask) | set_mask);
  end

  // Free, then save (wins over free), then a valid restore consumes its slot.
  always_comb begin
    valid_nxt = ckpt_valid;
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (ckpt_free_en && ckpt_free_id == CK_W'(k))
        valid_nxt[k] = 1'b0;
      if (save_ok && ckpt_save_id == CK_W'(k))
        valid_nxt[k] = 1'b1;
      if (rvalid && ckpt_restore_id == CK_W'(k))
        valid_nxt[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live       <= '0;
      ckpt_valid <= '0;
      ckpt_err   <= 1'b0;
      for (int k = 0; k < NUM_CKPT; k++)
        ckpt[k] <= '0;
    end else begin
      live       <= live_nxt;
      ckpt_valid <= valid_nxt;
      ckpt_err   <= err_nxt;
      for (int k = 0; k < NUM_CKPT; k++) begin
        if (save_ok && ckpt_save_id == CK_W'(k))
          ckpt[k] <= live_nxt;
        else
          ckpt[k] <= ckpt[k] | set_mask;
      end
    end
  end

endmodule
